// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle RV32I-subset control FSM with memory handshake and watchdog
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   opcode[6:0]           IR opcode, sampled only in DECODE
//   mem_ready             memory completes the current request this cycle
//   ir_load, mem_req      IR load strobe / memory request (FETCH, MEM)
//   mem_we                memory write (MEM of SW)
//   alu_src, alu_op[1:0]  datapath ALU controls
//   mem_to_reg, reg_write writeback source / regfile write strobe
//   branch, jalr_sel,     PC controls
//   jmp_sel
//   retire                one-cycle instruction-complete pulse
//   halted, illegal,      sticky status flags
//   bus_err
//   cycle_cnt,            free-running cycle and retired-instruction counters
//   instret_cnt

module multicycle_controller #(
  parameter  int CNT_W       = 32,
  parameter  int MEM_TIMEOUT = 16,
  localparam int TMO_W       = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             ir_load,
  output logic             mem_req,
  output logic             mem_we,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             branch,
  output logic             jalr_sel,
  output logic             jmp_sel,
  output logic             retire,
  output logic             halted,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_HALT = 7'b0000001;

  localparam logic [TMO_W-1:0] WAIT_LAST = TMO_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_I, C_LUI, C_LW, C_SW, C_BR, C_JAL, C_JALR
  } cls_t;

  state_t            state_q, state_d;
  cls_t              cls_q, cls_d;
  logic [TMO_W-1:0]  wait_q, wait_d;
  logic              illegal_q, illegal_d;
  logic              bus_err_q, bus_err_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic [CNT_W-1:0]  instret_q, instret_d;

  cls_t              dec_cls;
  logic              dec_valid;
  logic              dec_halt;
  logic              retire_now;

  // ---------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      cls_q     <= C_R;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  // ---------------------------------------------------------------
  // Opcode classification (only consumed in DECODE)
  // ---------------------------------------------------------------
  always_comb begin
    dec_cls   = C_R;
    dec_valid = 1'b1;
    dec_halt  = 1'b0;
    case (opcode)
      OP_R:    dec_cls = C_R;
      OP_I:    dec_cls = C_I;
      OP_LUI:  dec_cls = C_LUI;
      OP_LW:   dec_cls = C_LW;
      OP_SW:   dec_cls = C_SW;
      OP_BR:   dec_cls = C_BR;
      OP_JAL:  dec_cls = C_JAL;
      OP_JALR: dec_cls = C_JALR;
      OP_HALT: dec_halt = 1'b1;
      default: dec_valid = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    wait_d     = '0;          // any state change or mem_ready clears the watchdog
    illegal_d  = illegal_q;
    bus_err_d  = bus_err_q;
    retire_now = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d   = S_HALTED;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + TMO_W'(1);
        end
      end
      S_DECODE: begin
        if (dec_halt) begin
          state_d = S_HALTED;
        end else if (!dec_valid) begin
          state_d   = S_HALTED;
          illegal_d = 1'b1;
        end else begin
          cls_d   = dec_cls;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls_q)
          C_LW, C_SW: state_d = S_MEM;
          C_BR: begin
            retire_now = 1'b1;
            state_d    = S_FETCH;
          end
          default:    state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (cls_q == C_LW) begin
            state_d = S_WB;
          end else begin
            retire_now = 1'b1;
            state_d    = S_FETCH;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d   = S_HALTED;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + TMO_W'(1);
        end
      end
      S_WB: begin
        retire_now = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_HALTED;
    endcase

    cycle_d   = (state_q != S_HALTED) ? cycle_q + CNT_W'(1) : cycle_q;
    instret_d = retire_now ? instret_q + CNT_W'(1) : instret_q;
  end

  // ---------------------------------------------------------------
  // Output logic; everything is forced low while reset is held
  // ---------------------------------------------------------------
  always_comb begin
    ir_load     = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    alu_src     = 1'b0;
    alu_op      = 2'b00;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    branch      = 1'b0;
    jalr_sel    = 1'b0;
    jmp_sel     = 1'b0;
    retire      = 1'b0;
    halted      = 1'b0;
    illegal     = 1'b0;
    bus_err     = 1'b0;
    cycle_cnt   = '0;
    instret_cnt = '0;

    if (!reset) begin
      halted      = (state_q == S_HALTED);
      illegal     = illegal_q;
      bus_err     = bus_err_q;
      cycle_cnt   = cycle_q;
      instret_cnt = instret_q;
      retire      = retire_now;

      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          ir_load = mem_ready;
        end
        S_MEM: begin
          mem_req = 1'b1;
          mem_we  = (cls_q == C_SW);
        end
        S_WB:    reg_write = 1'b1;
        default: ;
      endcase

      // Datapath controls come from the latched class from EXEC through WB
      if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
        alu_src    = (cls_q == C_LW) || (cls_q == C_SW) || (cls_q == C_I) ||
                     (cls_q == C_JALR) || (cls_q == C_LUI);
        mem_to_reg = (cls_q == C_LW);
        jalr_sel   = (cls_q == C_JALR);
        jmp_sel    = (cls_q == C_JAL) || (cls_q == C_JALR);
        branch     = (cls_q == C_BR) && (state_q == S_EXEC);
        case (cls_q)
          C_BR:       alu_op = 2'b01;
          C_R, C_I:   alu_op = 2'b10;
          C_LUI:      alu_op = 2'b11;
          default:    alu_op = 2'b00;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller
module tb_multicycle_controller;

  localparam logic [6:0] R_ADDI = 7'b0010011;
  localparam logic [6:0] R_LUI  = 7'b0110111;
  localparam logic [6:0] R_LW   = 7'b0000011;
  localparam logic [6:0] R_SW   = 7'b0100011;
  localparam logic [6:0] R_BR   = 7'b1100011;
  localparam logic [6:0] R_JAL  = 7'b1101111;
  localparam logic [6:0] R_JALR = 7'b1100111;
  localparam logic [6:0] R_HALT = 7'b0000001;
  localparam logic [6:0] R_BAD  = 7'h7F;

  // Packed control snapshot bit masks
  localparam logic [14:0] IRL  = 15'h4000;
  localparam logic [14:0] MREQ = 15'h2000;
  localparam logic [14:0] MWE  = 15'h1000;
  localparam logic [14:0] ASRC = 15'h0800;
  localparam logic [14:0] OPBR = 15'h0200;
  localparam logic [14:0] OPRI = 15'h0400;
  localparam logic [14:0] OPLU = 15'h0600;
  localparam logic [14:0] M2R  = 15'h0100;
  localparam logic [14:0] REGW = 15'h0080;
  localparam logic [14:0] BRN  = 15'h0040;
  localparam logic [14:0] JALR = 15'h0020;
  localparam logic [14:0] JMP  = 15'h0010;
  localparam logic [14:0] RET  = 15'h0008;
  localparam logic [14:0] HLT  = 15'h0004;
  localparam logic [14:0] ILL  = 15'h0002;
  localparam logic [14:0] BERR = 15'h0001;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       ir_load, mem_req, mem_we, alu_src, mem_to_reg, reg_write;
  logic       branch, jalr_sel, jmp_sel, retire, halted, illegal, bus_err;
  logic [1:0] alu_op;
  logic [3:0] cycle_cnt, instret_cnt;

  multicycle_controller #(.CNT_W(4), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .ir_load(ir_load), .mem_req(mem_req), .mem_we(mem_we), .alu_src(alu_src),
    .alu_op(alu_op), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .branch(branch), .jalr_sel(jalr_sel), .jmp_sel(jmp_sel), .retire(retire),
    .halted(halted), .illegal(illegal), .bus_err(bus_err),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [14:0] ctl;
    logic [3:0] cc;
    logic [3:0] ic;
  } exp_t;

  exp_t  sb[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    t0 = 0;
  logic  probe = 1'b0;
  logic  halted_prev = 1'b0;
  string tname = "init";

  always @(posedge clk) cyc++;

  function automatic void push(int c, logic [14:0] ctl, int cc, int ic);
    exp_t e;
    e.cyc = c;
    e.ctl = ctl;
    e.cc  = 4'(cc);
    e.ic  = 4'(ic);
    sb.push_back(e);
  endfunction

  // Monitor: any visible DUT action (or a stimulus probe) pops one expectation
  always @(negedge clk) begin
    logic [14:0] act;
    logic        ev;
    exp_t        e;
    int          rel;
    act = {ir_load, mem_req, mem_we, alu_src, alu_op, mem_to_reg, reg_write,
           branch, jalr_sel, jmp_sel, retire, halted, illegal, bus_err};
    ev  = probe | ir_load | reg_write | retire | mem_we | branch | (halted & ~halted_prev);
    halted_prev = halted;
    rel = cyc - t0;
    if (ev) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL %s unexpected_event: got cyc=%0d ctl=%b cc=%0d ic=%0d, expected no event",
                 tname, rel, act, cycle_cnt, instret_cnt);
      end else begin
        e = sb.pop_front();
        if (e.cyc != rel || e.ctl != act || e.cc != cycle_cnt || e.ic != instret_cnt) begin
          errors++;
          $display("FAIL %s event: got cyc=%0d ctl=%b cc=%0d ic=%0d, expected cyc=%0d ctl=%b cc=%0d ic=%0d",
                   tname, rel, act, cycle_cnt, instret_cnt, e.cyc, e.ctl, e.cc, e.ic);
        end
      end
    end
  end

  task automatic step(input logic [6:0] op, input logic rdy);
    opcode    = op;
    mem_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic pstep(input logic [6:0] op, input logic rdy);
    probe = 1'b1;
    step(op, rdy);
    probe = 1'b0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    probe     = 1'b0;
    mem_ready = 1'b0;
    opcode    = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    t0    = cyc;
  endtask

  task automatic end_test();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s pending: got %0d unmatched expectations, expected 0", tname, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset state: outputs all zero even with mem_ready high
    tname = "reset"; reset = 1'b1; mem_ready = 1'b1; opcode = R_ADDI;
    @(posedge clk); #1;
    t0 = cyc;
    push(0, '0, 0, 0);
    pstep(R_ADDI, 1'b1);
    end_test();

    // ADDI with memory always ready
    tname = "addi"; do_reset();
    push(0, IRL | MREQ, 0, 0);
    push(3, ASRC | OPRI | REGW | RET, 3, 0);
    push(4, MREQ, 4, 1);
    repeat (4) step(R_ADDI, 1'b1);
    pstep('0, 1'b0);
    end_test();

    // LW with MEM stalled two cycles, ready on the third
    tname = "lw_wait"; do_reset();
    push(0, IRL | MREQ, 0, 0);
    push(3, MREQ | ASRC | M2R, 3, 0);
    push(4, MREQ | ASRC | M2R, 4, 0);
    push(5, MREQ | ASRC | M2R, 5, 0);
    push(6, ASRC | M2R | REGW | RET, 6, 0);
    push(7, MREQ, 7, 1);
    step(R_LW, 1'b1); step(R_LW, 1'b1); step(R_LW, 1'b0);
    pstep(R_LW, 1'b0); pstep(R_LW, 1'b0); pstep(R_LW, 1'b1);
    step(R_LW, 1'b0);
    pstep('0, 1'b0);
    end_test();

    // SW (opcode scrambled after DECODE) then BR
    tname = "sw_br"; do_reset();
    push(0, IRL | MREQ, 0, 0);
    push(3, MREQ | MWE | ASRC | RET, 3, 0);
    push(4, IRL | MREQ, 4, 1);
    push(6, BRN | OPBR | RET, 6, 1);
    push(7, MREQ, 7, 2);
    step(R_SW, 1'b1); step(R_SW, 1'b1); step(R_BAD, 1'b1); step(R_BAD, 1'b1);
    step(R_BR, 1'b1); step(R_BR, 1'b1); step(R_BR, 1'b1);
    pstep('0, 1'b0);
    end_test();

    // FETCH timeout after four waits; counters freeze
    tname = "timeout"; do_reset();
    push(4, HLT | BERR, 4, 0);
    push(7, HLT | BERR, 4, 0);
    repeat (7) step('0, 1'b0);
    pstep('0, 1'b0);
    end_test();

    // Ready on the fourth wait cycle wins over the timeout
    tname = "ready_last"; do_reset();
    push(3, IRL | MREQ, 3, 0);
    push(4, '0, 4, 0);
    repeat (3) step('0, 1'b0);
    step(R_ADDI, 1'b1);
    pstep(R_ADDI, 1'b0);
    end_test();

    // BR retires, then an illegal opcode halts without retiring
    tname = "illegal"; do_reset();
    push(0, IRL | MREQ, 0, 0);
    push(2, BRN | OPBR | RET, 2, 0);
    push(3, IRL | MREQ, 3, 1);
    push(5, HLT | ILL, 5, 1);
    push(6, HLT | ILL, 5, 1);
    repeat (3) step(R_BR, 1'b1);
    step(R_BAD, 1'b1); step(R_BAD, 1'b1); step('0, 1'b0);
    pstep('0, 1'b0);
    end_test();

    // HALT opcode: halted without illegal
    tname = "halt"; do_reset();
    push(0, IRL | MREQ, 0, 0);
    push(2, HLT, 2, 0);
    push(3, HLT, 2, 0);
    step(R_HALT, 1'b1); step(R_HALT, 1'b1); step('0, 1'b0);
    pstep('0, 1'b0);
    end_test();

    // JALR then LUI
    tname = "jalr_lui"; do_reset();
    push(0, IRL | MREQ, 0, 0);
    push(2, JALR | JMP | ASRC, 2, 0);
    push(3, JALR | JMP | ASRC | REGW | RET, 3, 0);
    push(4, IRL | MREQ, 4, 1);
    push(6, ASRC | OPLU, 6, 1);
    push(7, ASRC | OPLU | REGW | RET, 7, 1);
    push(8, MREQ, 8, 2);
    step(R_JALR, 1'b1); step(R_JALR, 1'b1); pstep(R_JALR, 1'b1); step(R_JALR, 1'b1);
    step(R_LUI, 1'b1); step(R_LUI, 1'b1); pstep(R_LUI, 1'b1); step(R_LUI, 1'b1);
    pstep('0, 1'b0);
    end_test();

    // Reset asserted during WB of JAL
    tname = "jal_reset"; do_reset();
    push(0, IRL | MREQ, 0, 0);
    push(2, JMP, 2, 0);
    push(3, '0, 0, 0);
    push(4, MREQ, 0, 0);
    step(R_JAL, 1'b1); step(R_JAL, 1'b1); pstep(R_JAL, 1'b1);
    reset = 1'b1;
    pstep(R_JAL, 1'b1);
    reset = 1'b0;
    pstep('0, 1'b0);
    end_test();

    // Back-to-back BRs: 4-bit cycle counter wraps 15 -> 0
    tname = "wrap"; do_reset();
    for (int k = 0; k < 6; k++) begin
      push(3 * k, IRL | MREQ, 3 * k, k);
      push(3 * k + 2, BRN | OPBR | RET, 3 * k + 2, k);
    end
    push(18, MREQ, 2, 6);
    repeat (18) step(R_BR, 1'b1);
    pstep('0, 1'b0);
    end_test();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
